// File: rtl/uart_file_loader_pkg.sv
// Shared FSM state encodings and file-transfer protocol constants for the UART file loader.
package uart_file_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_SIZE = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  localparam logic [7:0]  STX        = 8'h02;
  localparam logic [7:0]  ETX        = 8'h03;
  localparam logic [7:0]  EOT        = 8'h04;
  localparam int unsigned SIZE_BYTES = 4;

endpackage

// File: rtl/byte_word_packer.sv
// Packs bytes little-endian into a 32-bit word; the word is presented one cycle after its last byte.
// Holds one word until the memory accepts it; o_pend tells the producer to stop while a write is stalled.
module byte_word_packer (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_clr,
  input  logic        i_byte_vld,
  input  logic [7:0]  i_byte_dat,
  input  logic        i_last,
  input  logic        i_mem_rdy,
  output logic        o_mem_vld,
  output logic [31:0] o_mem_dat,
  output logic [3:0]  o_mem_strb,
  output logic        o_pend
);

  logic [1:0]  r_lane;
  logic [31:0] r_acc;
  logic [3:0]  r_acc_strb;
  logic        r_vld;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;

  logic [31:0] w_acc_nxt;
  logic [3:0]  w_strb_nxt;
  logic        w_flush;

  assign w_acc_nxt  = r_acc | ({24'd0, i_byte_dat} << {r_lane, 3'b000});
  assign w_strb_nxt = r_acc_strb | (4'b0001 << r_lane);
  assign w_flush    = i_byte_vld & ((r_lane == 2'd3) | i_last);

  // Accumulator and output word are separate so a byte can land while the previous word is being accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_lane     <= 2'd0;
      r_acc      <= 32'd0;
      r_acc_strb <= 4'd0;
      r_vld      <= 1'b0;
      r_wdata    <= 32'd0;
      r_wstrb    <= 4'd0;
    end else if (i_clr) begin
      r_lane     <= 2'd0;
      r_acc      <= 32'd0;
      r_acc_strb <= 4'd0;
      r_vld      <= 1'b0;
    end else begin
      if (w_flush) begin
        r_wdata    <= w_acc_nxt;
        r_wstrb    <= w_strb_nxt;
        r_acc      <= 32'd0;
        r_acc_strb <= 4'd0;
        r_lane     <= 2'd0;
      end else if (i_byte_vld) begin
        r_acc      <= w_acc_nxt;
        r_acc_strb <= w_strb_nxt;
        r_lane     <= r_lane + 2'd1;
      end
      if (w_flush) begin
        r_vld <= 1'b1;
      end else if (r_vld && i_mem_rdy) begin
        r_vld <= 1'b0;
      end
    end
  end

  assign o_mem_vld  = r_vld;
  assign o_mem_dat  = r_wdata;
  assign o_mem_strb = r_wstrb;
  assign o_pend     = r_vld & ~i_mem_rdy;

endmodule

// File: rtl/uart_file_loader.sv
// Requests a file over UART, reads a 4-byte LE size then the payload, and writes it to memory as 32-bit words.
// rx is throttled while a word write is stalled; the request byte waits on tx_ready.
module uart_file_loader
  import uart_file_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned MAX_BYTES = 65536,
  parameter int unsigned BASE_ADDR = 0,
  parameter logic [7:0]  REQ_CHAR  = STX
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       file_size
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_size_idx;
  logic [31:0]       r_file_size;
  logic [31:0]       r_byte_cnt;
  logic [ADDR_W-1:0] r_word_idx;
  logic              r_error;

  logic        w_rx_fire;
  logic        w_data_fire;
  logic        w_mem_fire;
  logic        w_pend;
  logic        w_all_rx;
  logic        w_last_byte;
  logic        w_start_ok;
  logic        w_size_last;
  logic [31:0] w_size_full;

  assign w_rx_fire   = rx_valid & rx_ready;
  assign w_data_fire = w_rx_fire & (r_state == ST_DATA);
  assign w_mem_fire  = mem_valid & mem_ready;
  assign w_all_rx    = (r_byte_cnt == r_file_size);
  assign w_last_byte = ((r_byte_cnt + 32'd1) == r_file_size);
  assign w_start_ok  = (r_state == ST_IDLE) & start;
  assign w_size_last = (r_size_idx == 2'(SIZE_BYTES - 1));
  assign w_size_full = {rx_data, r_file_size[23:0]};

  always_comb begin
    w_state_nxt = r_state;
    tx_valid    = 1'b0;
    rx_ready    = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_REQ;
      ST_REQ: begin
        tx_valid = 1'b1;
        if (tx_ready) w_state_nxt = ST_SIZE;
      end
      ST_SIZE: begin
        rx_ready = 1'b1;
        if (rx_valid && w_size_last) begin
          if (w_size_full == 32'd0)           w_state_nxt = ST_DONE;
          else if (w_size_full > MAX_BYTES)   w_state_nxt = ST_ERR;
          else                                w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        rx_ready = ~w_pend & ~w_all_rx;
        if (w_all_rx && w_mem_fire) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      ST_ERR:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_size_idx  <= 2'd0;
      r_file_size <= 32'd0;
      r_byte_cnt  <= 32'd0;
      r_word_idx  <= '0;
      r_error     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_ok) begin
        r_error     <= 1'b0;
        r_size_idx  <= 2'd0;
        r_file_size <= 32'd0;
        r_byte_cnt  <= 32'd0;
        r_word_idx  <= '0;
      end
      if (r_state == ST_SIZE && rx_valid) begin
        r_file_size[{r_size_idx, 3'b000} +: 8] <= rx_data;
        r_size_idx                             <= r_size_idx + 2'd1;
      end
      if (w_data_fire) r_byte_cnt <= r_byte_cnt + 32'd1;
      if (w_mem_fire)  r_word_idx <= r_word_idx + 1'b1;
      if (w_state_nxt == ST_ERR) r_error <= 1'b1;
    end
  end

  byte_word_packer u_packer (
    .clk        (clk),
    .rstn       (rstn),
    .i_clr      (r_state == ST_IDLE),
    .i_byte_vld (w_data_fire),
    .i_byte_dat (rx_data),
    .i_last     (w_last_byte),
    .i_mem_rdy  (mem_ready),
    .o_mem_vld  (mem_valid),
    .o_mem_dat  (mem_wdata),
    .o_mem_strb (mem_wstrb),
    .o_pend     (w_pend)
  );

  assign mem_addr  = ADDR_W'(BASE_ADDR) + r_word_idx;
  assign tx_data   = tx_valid ? REQ_CHAR : 8'd0;
  assign busy      = (r_state == ST_REQ) | (r_state == ST_SIZE) |
                     (r_state == ST_DATA) | (r_state == ST_DONE);
  assign done      = (r_state == ST_DONE);
  assign error     = r_error;
  assign file_size = r_file_size;

endmodule
